// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Front-end for the 4-bit combinational ALU. It takes one command at a time
//   over cmd_valid/cmd_ready and drives the operands and opcode onto alu_*.
//   After SETTLE clock edges it captures {alu_co, alu_c} and returns the result
//   over rsp_valid/rsp_ready.
//
// Ports
//   clk, rst_n             clock; synchronous active-low reset
//   cmd_valid/cmd_ready    command handshake; cmd_a, cmd_b, cmd_op are the payload
//   alu_a/alu_b/alu_op     outputs to the ALU inputs, held stable until the next accept
//   alu_c/alu_co           ALU result inputs
//   rsp_valid/rsp_ready    response handshake; rsp_c, rsp_co, rsp_err are the payload
//   busy                   high while an operation is in flight (WAIT or RESP)
//   op_count               completed response handshakes, wraps modulo 2^CNTW
module alu_cmd_sequencer #(
    parameter int W      = 4,
    parameter int OPW    = 3,
    parameter int SETTLE = 1,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [W-1:0]    cmd_a,
    input  logic [W-1:0]    cmd_b,
    input  logic [OPW-1:0]  cmd_op,
    output logic [W-1:0]    alu_a,
    output logic [W-1:0]    alu_b,
    output logic [OPW-1:0]  alu_op,
    input  logic [W-1:0]    alu_c,
    input  logic            alu_co,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [W-1:0]    rsp_c,
    output logic            rsp_co,
    output logic            rsp_err,
    output logic            busy,
    output logic [CNTW-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    // Counter is loaded with SETTLE-1 so capture lands exactly SETTLE edges after accept.
    localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
    localparam logic [OPW-1:0]  OP_LAST   = OPW'(4);
    localparam logic [CNTW-1:0] CNT_ONE   = CNTW'(1);

    state_t     state, state_nxt;
    logic [3:0] settle_cnt;
    logic       accept;
    logic       illegal;

    assign cmd_ready = (state == IDLE) && rst_n;
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign illegal   = (alu_op > OP_LAST);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)            state_nxt = WAIT;
            WAIT:    if (settle_cnt == 4'd0) state_nxt = RESP;
            RESP:    if (rsp_ready)         state_nxt = IDLE;
            default:                        state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_op     <= '0;
            rsp_c      <= '0;
            rsp_co     <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_valid  <= 1'b0;
            settle_cnt <= 4'd0;
            op_count   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a      <= cmd_a;
                        alu_b      <= cmd_b;
                        alu_op     <= cmd_op;
                        settle_cnt <= SETTLE_LD;
                    end
                end
                WAIT: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end else begin
                        // Illegal opcodes still drive the ALU, but whatever it
                        // produces is masked so consumers see a clean zero result.
                        rsp_c     <= illegal ? '0 : alu_c;
                        rsp_co    <= illegal ? 1'b0 : alu_co;
                        rsp_err   <= illegal;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Sequential front-end that drives the team's 4-bit combinational ALU. It accepts one operation command at a time over a valid/ready handshake and drives the operands and opcode onto the ALU inputs. It waits a programmable settle time, captures {co, c}, and returns the result over a second valid/ready handshake. It sits between a command source (test controller or microsequencer) and the ALU instance; the ALU's a/b/op inputs connect to this block's alu_* outputs, and its c/co outputs connect back to alu_c/alu_co.

Parameters:
W, 4, operand/result width; must match the ALU.
OPW, 3, opcode width.
SETTLE, 1, clock edges between driving the ALU and capturing its result; legal range 1..15.
CNTW, 8, width of the completed-operation counter.

Ports:
clk  input  1  single clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_a  input  W  operand a
cmd_b  input  W  operand b
cmd_op  input  OPW  opcode: 000 NOT a, 001 AND, 010 OR, 011 XOR, 100 ADD; 101-111 illegal
alu_a  output  W  to ALU a
alu_b  output  W  to ALU b
alu_op  output  OPW  to ALU op
alu_c  input  W  from ALU c
alu_co  input  1  from ALU co
rsp_valid  output  1  result present
rsp_ready  input  1  consumer accepts result
rsp_c  output  W  captured result
rsp_co  output  1  captured carry
rsp_err  output  1  command carried an illegal opcode
busy  output  1  high in WAIT or RESP
op_count  output  CNTW  count of completed response handshakes

Behaviour:
- Reset: clk and one synchronous active-low reset rst_n; no asynchronous paths. While rst_n=0 at an edge: state<=IDLE, alu_a/alu_b/alu_op<=0, rsp_c/rsp_co/rsp_err<=0, rsp_valid<=0, settle counter<=0, op_count<=0. cmd_ready = (state==IDLE) && rst_n, so it is 0 while rst_n is low.
- States: IDLE, WAIT, RESP. busy = (state!=IDLE).
- IDLE: cmd_ready=1. On an edge with cmd_valid && cmd_ready:
  - latch cmd_a/cmd_b/cmd_op into alu_a/alu_b/alu_op;
  - load settle counter with SETTLE-1;
  - go to WAIT.
  cmd_* are ignored in all other states.
- WAIT: alu_* held stable. At each edge, if counter != 0, decrement it. At the edge where counter==0:
  - capture rsp_c<=alu_c and rsp_co<=alu_co;
  - set rsp_err<=(alu_op>3'b100);
  - if illegal, force rsp_c<=0 and rsp_co<=0 regardless of ALU output;
  - set rsp_valid<=1 and go to RESP.
- Latency: rsp_valid rises exactly SETTLE edges after the command-accept edge (SETTLE=1: accept at edge k, capture and rsp_valid high after edge k+1).
- RESP: rsp_valid=1; rsp_c/rsp_co/rsp_err held stable until handshake. On an edge with rsp_ready=1:
  - rsp_valid<=0;
  - op_count<=op_count+1, wrapping from 2^CNTW-1 to 0;
  - go to IDLE.
  rsp_ready held low stalls indefinitely with no data change. rsp_ready=1 while rsp_valid=0 has no effect.
- No overlap: a new command is accepted no earlier than the edge after the response handshake. Back-to-back throughput is one op per SETTLE+2 cycles.
- alu_* hold the last command's values in IDLE until the next accept. rsp_c/rsp_co/rsp_err keep their last values after the handshake (don't-care while rsp_valid=0).
- Illegal ops still drive the ALU and still count in op_count.
- Reset mid-operation (WAIT or RESP): the operation is discarded with no response, and every register takes the reset values above at that edge.
- Arithmetic: the block does no arithmetic on data; W-bit result plus 1-bit carry is passed through unchanged.

Test Plan:
1. ADD with carry: cmd a=4'hA, b=4'h7, op=100, rsp_ready=1, SETTLE=1 -> rsp_valid rises 1 edge after accept with rsp_c=4'h1, rsp_co=1, rsp_err=0; op_count 0->1; cmd_ready returns high the cycle after the handshake.
2. Logic ops back-to-back: NOT a=4'h5 -> c=4'hA, co=0; AND a=4'hC, b=4'hA -> c=4'h8; OR -> c=4'hE; XOR -> c=4'h6. cmd_valid held high throughout; exactly 4 accepts with SETTLE+2 cycle spacing, op_count=4.
3. Backpressure: ADD a=4'h3, b=4'h4, rsp_ready low for 10 cycles -> rsp_valid stays 1, rsp_c=4'h7 stable, cmd_ready=0, and a second cmd_valid pulse is ignored; after rsp_ready=1 the single response completes and op_count increments by 1 only.
4. Illegal opcode: op=110, a=4'hF, b=4'hF -> rsp_err=1, rsp_c=0, rsp_co=0; op_count increments.
5. Reset mid-op: accept ADD with SETTLE=4 and assert rst_n=0 during WAIT -> no rsp_valid ever for that command, all outputs 0 after the reset edge, cmd_ready=1 the first cycle after rst_n returns high.
6. Counter wrap and SETTLE: run 256 ops with CNTW=8 -> op_count wraps 255->0. With SETTLE=3, check rsp_valid rises exactly 3 edges after the accept edge.
